mem_stage_lsu: RTL and testbench

Parametrised load/store unit for the MEM pipeline stage, replacing a purely combinational memory pass-through.
- Drives a req/ack data bus with wait states: byte enables, store-data lane replication, load alignment with sign/zero extension.
- Detects misaligned accesses and enforces a bus timeout.
- Stalls upstream while a transaction is outstanding.
- Registers all results toward WB.

---
 rtl/mem_stage_lsu.sv | 196 +++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// ============================================================================
// mem_stage_lsu : MEM-stage load/store unit with req/ack bus, alignment
//                 checks, bus timeout and registered writeback outputs.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module mem_stage_lsu #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic                in_memop,
  input  logic                in_memwr,
  input  logic [1:0]          in_size,
  input  logic                in_unsigned,
  input  logic [ADDR_W-1:0]   in_addr,
  input  logic [DATA_W-1:0]   in_alu,
  input  logic [DATA_W-1:0]   in_stdata,
  input  logic [4:0]          in_rd,
  input  logic                in_regwrite,
  output logic                stall_out,
  output logic                bus_req,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W/8-1:0] bus_be,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic [DATA_W-1:0]   bus_rdata,
  input  logic                bus_ack,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_data,
  output logic [4:0]          out_rd,
  output logic                out_regwrite,
  output logic                exc_misalign,
  output logic                exc_buserr,
  output logic [ADDR_W-1:0]   exc_addr
);

  localparam int BE_W   = DATA_W / 8;
  localparam int LANE_W = $clog2(BE_W);

  typedef enum logic [0:0] {IDLE = 1'b0, BUS = 1'b1} state_t;

  state_t              state_q;
  logic [7:0]          cnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   bus_addr_q;
  logic [BE_W-1:0]     bus_be_q;
  logic [DATA_W-1:0]   bus_wdata_q;
  logic                bus_we_q;
  logic [1:0]          size_q;
  logic                uns_q;
  logic [LANE_W-1:0]   lane_q;
  logic                rw_q;
  logic                out_valid_q;
  logic [DATA_W-1:0]   out_data_q;
  logic [4:0]          out_rd_q;
  logic                out_regwrite_q;
  logic                exc_misalign_q;
  logic                exc_buserr_q;
  logic [ADDR_W-1:0]   exc_addr_q;

  logic [7:0]          be_base_d;
  logic [2:0]          align_mask_d;
  logic                misalign_d;
  logic [BE_W-1:0]     be_d;
  logic [DATA_W-1:0]   wdata_d;
  logic [DATA_W-1:0]   rshift_d;
  logic [DATA_W-1:0]   fill_d;
  logic                sign_d;
  logic [DATA_W-1:0]   load_d;

  // Request side: byte enables, alignment and store-lane replication.
  always_comb begin
    be_base_d    = 8'h00;
    align_mask_d = 3'b000;
    case (in_size)
      2'd0:    begin be_base_d = 8'h01; align_mask_d = 3'b000; end
      2'd1:    begin be_base_d = 8'h03; align_mask_d = 3'b001; end
      2'd2:    begin be_base_d = 8'h0F; align_mask_d = 3'b011; end
      default: begin be_base_d = 8'hFF; align_mask_d = 3'b111; end
    endcase
    misalign_d = (|(in_addr[2:0] & align_mask_d)) || ((in_size == 2'd3) && (DATA_W == 32));
    be_d       = BE_W'(be_base_d) << in_addr[LANE_W-1:0];
    wdata_d    = '0;
    for (int i = 0; i < BE_W; i++) begin
      wdata_d[8*i +: 8] = in_stdata[8*(i & ((1 << in_size) - 1)) +: 8];
    end
  end

  // Response side: right-justify the addressed lanes, then sign/zero fill.
  always_comb begin
    rshift_d = bus_rdata >> {lane_q, 3'b000};
    sign_d   = 1'b0;
    fill_d   = '0;
    case (size_q)
      2'd0:    begin sign_d = rshift_d[7];        fill_d = {DATA_W{1'b1}} << 8;  end
      2'd1:    begin sign_d = rshift_d[15];       fill_d = {DATA_W{1'b1}} << 16; end
      2'd2:    begin sign_d = rshift_d[31];       fill_d = {DATA_W{1'b1}} << 32; end
      default: begin sign_d = rshift_d[DATA_W-1]; fill_d = '0;                   end
    endcase
    load_d = (sign_d && !uns_q) ? (rshift_d | fill_d) : (rshift_d & ~fill_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      addr_q         <= '0;
      bus_addr_q     <= '0;
      bus_be_q       <= '0;
      bus_wdata_q    <= '0;
      bus_we_q       <= 1'b0;
      size_q         <= '0;
      uns_q          <= 1'b0;
      lane_q         <= '0;
      rw_q           <= 1'b0;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      out_rd_q       <= '0;
      out_regwrite_q <= 1'b0;
      exc_misalign_q <= 1'b0;
      exc_buserr_q   <= 1'b0;
      exc_addr_q     <= '0;
    end else begin
      out_valid_q    <= 1'b0;
      exc_misalign_q <= 1'b0;
      exc_buserr_q   <= 1'b0;
      if (state_q == IDLE) begin
        if (in_valid) begin
          out_rd_q <= in_rd;
          if (!in_memop) begin
            out_valid_q    <= 1'b1;
            out_data_q     <= in_alu;
            out_regwrite_q <= in_regwrite;
          end else if (misalign_d) begin
            out_valid_q    <= 1'b1;
            out_data_q     <= '0;
            out_regwrite_q <= 1'b0;
            exc_misalign_q <= 1'b1;
            exc_addr_q     <= in_addr;
          end else begin
            state_q     <= BUS;
            cnt_q       <= '0;
            addr_q      <= in_addr;
            bus_addr_q  <= {in_addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
            bus_be_q    <= be_d;
            bus_wdata_q <= wdata_d;
            bus_we_q    <= in_memwr;
            size_q      <= in_size;
            uns_q       <= in_unsigned;
            lane_q      <= in_addr[LANE_W-1:0];
            rw_q        <= in_regwrite;
          end
        end
      end else begin
        // Ack is checked first so it wins over a simultaneous timeout.
        if (bus_ack) begin
          state_q        <= IDLE;
          out_valid_q    <= 1'b1;
          out_data_q     <= bus_we_q ? '0 : load_d;
          out_regwrite_q <= bus_we_q ? 1'b0 : rw_q;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          state_q        <= IDLE;
          out_valid_q    <= 1'b1;
          out_data_q     <= '0;
          out_regwrite_q <= 1'b0;
          exc_buserr_q   <= 1'b1;
          exc_addr_q     <= addr_q;
        end else begin
          cnt_q <= cnt_q + 8'd1;
        end
      end
    end
  end

  assign stall_out    = (state_q == BUS);
  assign bus_req      = (state_q == BUS);
  assign bus_we       = bus_we_q;
  assign bus_addr     = bus_addr_q;
  assign bus_be       = bus_be_q;
  assign bus_wdata    = bus_wdata_q;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_rd       = out_rd_q;
  assign out_regwrite = out_regwrite_q;
  assign exc_misalign = exc_misalign_q;
  assign exc_buserr   = exc_buserr_q;
  assign exc_addr     = exc_addr_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
// ============================================================================
// tb_mem_stage_lsu : scoreboard bench for a 32-bit (TIMEOUT=4) and a 64-bit
//                    instance of mem_stage_lsu.
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_mem_stage_lsu;

  localparam int TO0 = 4;
  localparam int TO1 = 15;

  typedef struct {
    logic [63:0] data;
    logic [4:0]  rd;
    logic        rw;
    logic        mis;
    logic        berr;
    logic [31:0] ea;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [7:0]  be;
    logic [63:0] wd;
    logic        we;
  } bus_t;

  exp_t eq[2][$];
  bus_t bq[2][$];

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   stall_cnt = 0;

  int          rsp_wait[2];
  bit          rsp_noack[2];
  logic [63:0] rsp_data[2];
  int          bcnt[2];
  bit          force_ack[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 32-bit instance signals
  logic        a_valid, a_memop, a_memwr, a_uns, a_rw;
  logic [1:0]  a_size;
  logic [31:0] a_addr, a_alu, a_st;
  logic [4:0]  a_rd;
  logic        a_stall, a_req, a_we, a_ack, a_ov, a_orw, a_mis, a_berr;
  logic [31:0] a_baddr, a_wdata, a_rdata, a_od, a_eaddr;
  logic [3:0]  a_be;
  logic [4:0]  a_ord;

  // 64-bit instance signals
  logic        b_valid, b_memop, b_memwr, b_uns, b_rw;
  logic [1:0]  b_size;
  logic [31:0] b_addr;
  logic [63:0] b_alu, b_st;
  logic [4:0]  b_rd;
  logic        b_stall, b_req, b_we, b_ack, b_ov, b_orw, b_mis, b_berr;
  logic [31:0] b_baddr, b_eaddr;
  logic [63:0] b_wdata, b_rdata, b_od;
  logic [7:0]  b_be;
  logic [4:0]  b_ord;

  mem_stage_lsu #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(TO0)) u_d32 (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_memop(a_memop), .in_memwr(a_memwr),
    .in_size(a_size), .in_unsigned(a_uns), .in_addr(a_addr), .in_alu(a_alu),
    .in_stdata(a_st), .in_rd(a_rd), .in_regwrite(a_rw), .stall_out(a_stall),
    .bus_req(a_req), .bus_we(a_we), .bus_addr(a_baddr), .bus_be(a_be),
    .bus_wdata(a_wdata), .bus_rdata(a_rdata), .bus_ack(a_ack), .out_valid(a_ov),
    .out_data(a_od), .out_rd(a_ord), .out_regwrite(a_orw), .exc_misalign(a_mis),
    .exc_buserr(a_berr), .exc_addr(a_eaddr));

  mem_stage_lsu #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(TO1)) u_d64 (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in_memop(b_memop), .in_memwr(b_memwr),
    .in_size(b_size), .in_unsigned(b_uns), .in_addr(b_addr), .in_alu(b_alu),
    .in_stdata(b_st), .in_rd(b_rd), .in_regwrite(b_rw), .stall_out(b_stall),
    .bus_req(b_req), .bus_we(b_we), .bus_addr(b_baddr), .bus_be(b_be),
    .bus_wdata(b_wdata), .bus_rdata(b_rdata), .bus_ack(b_ack), .out_valid(b_ov),
    .out_data(b_od), .out_rd(b_ord), .out_regwrite(b_orw), .exc_misalign(b_mis),
    .exc_buserr(b_berr), .exc_addr(b_eaddr));

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h, wanted %h", nm, act, want);
    end
  endfunction

  task automatic mon(input int d, input logic ov, input logic [63:0] od, input logic [4:0] ord,
                     input logic orw, input logic mis, input logic berr, input logic [31:0] ea,
                     input logic first, input logic [31:0] ba, input logic [7:0] be,
                     input logic [63:0] wd, input logic we);
    exp_t  e;
    bus_t  b;
    string p;
    p = (d == 0) ? "d32" : "d64";
    if (eq[d].size() > 0 && eq[d][0].cyc < cyc) begin
      total++; bad++;
      $display("FAIL %s missing result: none by cycle %0d, wanted one at cycle %0d", p, cyc, eq[d][0].cyc);
      void'(eq[d].pop_front());
    end
    if (ov === 1'b1) begin
      if (eq[d].size() == 0) begin
        total++; bad++;
        $display("FAIL %s unexpected out_valid at cycle %0d, wanted none", p, cyc);
      end else begin
        e = eq[d].pop_front();
        chk({p, " latency cycle"}, 64'(cyc), 64'(e.cyc));
        chk({p, " exc_misalign"}, {63'b0, mis}, {63'b0, e.mis});
        chk({p, " exc_buserr"}, {63'b0, berr}, {63'b0, e.berr});
        chk({p, " out_regwrite"}, {63'b0, orw}, {63'b0, e.rw});
        if (e.mis || e.berr) chk({p, " exc_addr"}, {32'b0, ea}, {32'b0, e.ea});
        if (e.rw) begin
          chk({p, " out_data"}, od, e.data);
          chk({p, " out_rd"}, {59'b0, ord}, {59'b0, e.rd});
        end
      end
    end
    if (first) begin
      if (bq[d].size() == 0) begin
        total++; bad++;
        $display("FAIL %s unexpected bus_req at cycle %0d, wanted none", p, cyc);
      end else begin
        b = bq[d].pop_front();
        chk({p, " bus_addr"}, {32'b0, ba}, {32'b0, b.a});
        chk({p, " bus_be"}, {56'b0, be}, {56'b0, b.be});
        chk({p, " bus_wdata"}, wd, b.wd);
        chk({p, " bus_we"}, {63'b0, we}, {63'b0, b.we});
      end
    end
  endtask

  // Bus responders and monitors, evaluated mid-cycle.
  always @(negedge clk) begin
    if (a_req === 1'b1) bcnt[0]++; else bcnt[0] = 0;
    if (a_stall === 1'b1) stall_cnt++;
    a_ack   = (a_req === 1'b1) ? (!rsp_noack[0] && bcnt[0] == rsp_wait[0] + 1) : force_ack[0];
    a_rdata = rsp_data[0][31:0];
    mon(0, a_ov, {32'b0, a_od}, a_ord, a_orw, a_mis, a_berr, a_eaddr,
        (a_req === 1'b1) && bcnt[0] == 1, a_baddr, {4'b0, a_be}, {32'b0, a_wdata}, a_we);
  end

  always @(negedge clk) begin
    if (b_req === 1'b1) bcnt[1]++; else bcnt[1] = 0;
    b_ack   = (b_req === 1'b1) ? (!rsp_noack[1] && bcnt[1] == rsp_wait[1] + 1) : force_ack[1];
    b_rdata = rsp_data[1];
    mon(1, b_ov, b_od, b_ord, b_orw, b_mis, b_berr, b_eaddr,
        (b_req === 1'b1) && bcnt[1] == 1, b_baddr, b_be, b_wdata, b_we);
  end

  task automatic issue(input int d, input bit memop, input bit wr, input logic [1:0] sz,
                       input bit uns, input logic [31:0] addr, input logic [63:0] alu,
                       input logic [63:0] st, input int lat, input logic [63:0] edata,
                       input bit erw, input bit mis, input bit berr, input bit busexp,
                       input logic [31:0] ebaddr, input logic [7:0] ebe, input logic [63:0] ewd);
    exp_t e;
    bus_t b;
    @(posedge clk); #1;
    if (d == 0) begin
      a_valid = 1; a_memop = memop; a_memwr = wr; a_size = sz; a_uns = uns;
      a_addr = addr; a_alu = alu[31:0]; a_st = st[31:0]; a_rd = 5'd9; a_rw = 1;
    end else begin
      b_valid = 1; b_memop = memop; b_memwr = wr; b_size = sz; b_uns = uns;
      b_addr = addr; b_alu = alu; b_st = st; b_rd = 5'd9; b_rw = 1;
    end
    e.data = edata; e.rd = 5'd9; e.rw = erw; e.mis = mis; e.berr = berr; e.ea = addr;
    e.cyc = cyc + lat;
    eq[d].push_back(e);
    if (busexp) begin
      b.a = ebaddr; b.be = ebe; b.wd = ewd; b.we = wr;
      bq[d].push_back(b);
    end
    @(posedge clk); #1;
    if (d == 0) a_valid = 0; else b_valid = 0;
  endtask

  task automatic alu(input int d, input logic [63:0] v);
    issue(d, 0, 0, 2'd0, 0, 32'h0, v, 64'h0, 1, v, 1, 0, 0, 0, 32'h0, 8'h0, 64'h0);
  endtask

  // wt < 0 means the responder never acks (timeout path).
  task automatic ld(input int d, input logic [1:0] sz, input bit uns, input logic [31:0] addr,
                    input int wt, input logic [63:0] rdata, input logic [63:0] edata,
                    input logic [31:0] ebaddr, input logic [7:0] ebe);
    int to;
    to = (d == 0) ? TO0 : TO1;
    rsp_wait[d] = (wt < 0) ? 0 : wt;
    rsp_noack[d] = (wt < 0);
    rsp_data[d] = rdata;
    issue(d, 1, 0, sz, uns, addr, 64'h0, 64'h0, (wt < 0) ? 1 + to : 2 + wt, edata,
          (wt >= 0), 0, (wt < 0), 1, ebaddr, ebe, 64'h0);
  endtask

  task automatic st(input int d, input logic [1:0] sz, input logic [31:0] addr,
                    input logic [63:0] sd, input int wt, input logic [31:0] ebaddr,
                    input logic [7:0] ebe, input logic [63:0] ewd);
    rsp_wait[d] = wt;
    rsp_noack[d] = 0;
    issue(d, 1, 1, sz, 0, addr, 64'h0, sd, 2 + wt, 64'h0, 0, 0, 0, 1, ebaddr, ebe, ewd);
  endtask

  task automatic misal(input int d, input bit wr, input logic [1:0] sz, input logic [31:0] addr);
    issue(d, 1, wr, sz, 0, addr, 64'h0, 64'h0, 1, 64'h0, 0, 1, 0, 0, 32'h0, 8'h0, 64'h0);
  endtask

  task automatic done(input int d);
    int n;
    n = 0;
    while (n < 60 && !(eq[d].size() == 0 && ((d == 0) ? a_stall : b_stall) === 1'b0)) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 60) begin
      total++; bad++;
      $display("FAIL d%0d drain: %0d results still pending after 60 cycles, wanted 0", d, eq[d].size());
      eq[d].delete();
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    a_valid = 0; a_memop = 0; a_memwr = 0; a_size = 0; a_uns = 0; a_addr = 0;
    a_alu = 0; a_st = 0; a_rd = 0; a_rw = 0;
    b_valid = 0; b_memop = 0; b_memwr = 0; b_size = 0; b_uns = 0; b_addr = 0;
    b_alu = 0; b_st = 0; b_rd = 0; b_rw = 0;
    for (int k = 0; k < 2; k++) begin
      rsp_wait[k] = 0; rsp_noack[k] = 0; rsp_data[k] = 0; bcnt[k] = 0; force_ack[k] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("d32 reset stall/req/we/valid/exc", {59'b0, a_stall, a_req, a_we, a_ov, a_mis | a_berr}, 64'h0);
    chk("d32 reset bus addr/be/wdata", {a_baddr, a_wdata} | {60'b0, a_be}, 64'h0);
    chk("d32 reset out data/rd/rw/exc_addr", {a_od, a_eaddr} | {58'b0, a_ord, a_orw}, 64'h0);
    chk("d64 reset stall/req/we/valid/exc", {59'b0, b_stall, b_req, b_we, b_ov, b_mis | b_berr}, 64'h0);
    chk("d64 reset bus/out data", b_wdata | b_od | {b_baddr, b_eaddr} | {56'b0, b_be}, 64'h0);
    rst = 0;

    // 32-bit datapath
    alu(0, 64'hDEAD_BEEF); done(0);
    ld(0, 2'd0, 0, 32'h1003, 0, 64'h80FF_1234, 64'hFFFF_FF80, 32'h1000, 8'h8); done(0);
    ld(0, 2'd0, 1, 32'h1003, 1, 64'h80FF_1234, 64'h0000_0080, 32'h1000, 8'h8); done(0);
    stall_cnt = 0;
    st(0, 2'd1, 32'h2002, 64'h0000_ABCD, 3, 32'h2000, 8'hC, 64'hABCD_ABCD); done(0);
    chk("d32 store stall cycles", 64'(stall_cnt), 64'd4);
    st(0, 2'd2, 32'h0010, 64'h1234_5678, 0, 32'h0010, 8'hF, 64'h1234_5678); done(0);
    st(0, 2'd0, 32'h0001, 64'h0000_00AB, 2, 32'h0000, 8'h2, 64'hABAB_ABAB); done(0);
    misal(0, 0, 2'd2, 32'h1001); done(0);
    misal(0, 0, 2'd1, 32'h1001); done(0);
    misal(0, 1, 2'd3, 32'h1000); done(0);
    ld(0, 2'd1, 0, 32'h1002, 1, 64'h7FFF_8001, 64'h0000_7FFF, 32'h1000, 8'hC); done(0);
    ld(0, 2'd1, 0, 32'h0002, 0, 64'h8001_0000, 64'hFFFF_8001, 32'h0000, 8'hC); done(0);

    // Timeout followed by a late ack in IDLE
    ld(0, 2'd2, 0, 32'h3004, -1, 64'h0, 64'h0, 32'h3004, 8'hF); done(0);
    @(posedge clk); #1;
    force_ack[0] = 1;
    @(posedge clk); #1;
    force_ack[0] = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("d32 stall after late ack", {63'b0, a_stall}, 64'h0);
    alu(0, 64'h0BAD_F00D); done(0);

    // Reset in BUS cycle 2 abandons the load
    ld(0, 2'd2, 0, 32'h0040, -1, 64'h0, 64'h0, 32'h0040, 8'hF);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("d32 bus_req after mid-bus reset", {63'b0, a_req}, 64'h0);
    chk("d32 stall after mid-bus reset", {63'b0, a_stall}, 64'h0);
    chk("d32 out_valid/exc after mid-bus reset", {61'b0, a_ov, a_mis, a_berr}, 64'h0);
    eq[0].delete();
    alu(0, 64'h1357_9BDF); done(0);

    // 64-bit datapath
    ld(1, 2'd2, 1, 32'h4, 0, 64'h8000_0001_0000_0000, 64'h0000_0000_8000_0001, 32'h0, 8'hF0); done(1);
    ld(1, 2'd2, 0, 32'h4, 0, 64'h8000_0001_0000_0000, 64'hFFFF_FFFF_8000_0001, 32'h0, 8'hF0); done(1);
    ld(1, 2'd3, 0, 32'h8, 1, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 32'h8, 8'hFF); done(1);
    ld(1, 2'd0, 0, 32'h7, 0, 64'h7F00_0000_0000_0000, 64'h0000_0000_0000_007F, 32'h0, 8'h80); done(1);
    misal(1, 0, 2'd3, 32'hC); done(1);
    st(1, 2'd0, 32'h5, 64'hEE, 0, 32'h0, 8'h20, 64'hEEEE_EEEE_EEEE_EEEE); done(1);
    st(1, 2'd1, 32'h6, 64'hBEEF, 2, 32'h0, 8'hC0, 64'hBEEF_BEEF_BEEF_BEEF); done(1);
    alu(1, 64'hFEDC_BA98_7654_3210); done(1);

    repeat (2) @(posedge clk);
    #1;
    chk("d32 unissued bus requests", 64'(bq[0].size()), 64'h0);
    chk("d64 unissued bus requests", 64'(bq[1].size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
